// File: rtl/add_sub_seq_nbit.sv
// add_sub_seq_nbit: multi-cycle chunked two's-complement add/sub with valid/ready handshakes; optional accumulator via `ACCUM_EN
module add_sub_seq_nbit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
`ifdef ACCUM_EN
  ,
  input  logic             acc_sel
`endif
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  generate
    if (WIDTH < 2 || WIDTH % CHUNK != 0) begin : g_bad_params
      $error("add_sub_seq_nbit: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, s_q, s_d;
  logic              c_q, c_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
  logic [WIDTH-1:0]  a_src;
  logic [CHUNK-1:0]  ca, cb, cs;
  logic              cc, last, msb_cin;
`ifdef ACCUM_EN
  logic [WIDTH-1:0]  acc_q, acc_d;
  assign a_src = acc_sel ? acc_q : a;
`else
  assign a_src = a;
`endif
  assign ca       = a_q[k_q*CHUNK +: CHUNK];
  assign cb       = b_q[k_q*CHUNK +: CHUNK];
  assign {cc, cs} = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, c_q};
  assign last     = (k_q == KW'(N - 1));
  assign msb_cin  = ca[CHUNK-1] ^ cb[CHUNK-1] ^ cs[CHUNK-1];
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign neg  = neg_q;
  // Next-state: accept operands, ripple one chunk per cycle, publish result only when complete
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    s_d     = s_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
`ifdef ACCUM_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_src;
          b_d     = b ^ {WIDTH{mode}};
          c_d     = mode;
          k_d     = '0;
          s_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        s_d[k_q*CHUNK +: CHUNK] = cs;
        c_d = cc;
        k_d = k_q + 1'b1;
        if (last) begin
          state_d = DONE;
          sum_d   = s_d;
          cout_d  = cc;
          ovf_d   = msb_cin ^ cc;
          zero_d  = (s_d == '0);
          neg_d   = s_d[WIDTH-1];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef ACCUM_EN
          acc_d   = sum_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers; reset aborts any op in flight and clears the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      s_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
`ifdef ACCUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      s_q     <= s_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
`ifdef ACCUM_EN
      acc_q   <= acc_d;
`endif
    end
  end
endmodule

// File: tb/tb_add_sub_seq_nbit.sv
// tb_add_sub_seq_nbit: directed self-checking bench for add_sub_seq_nbit
module tb_add_sub_seq_nbit;
`ifdef ACCUM_EN
  localparam int CH = 8;
`else
  localparam int CH = 2;
`endif
  localparam int W = 8;
  localparam int N = W / CH;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, mode = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, ovf, zero, neg;
  logic [W-1:0] sum;
`ifdef ACCUM_EN
  logic acc_sel = 1'b0;
`endif
  int checks = 0, failures = 0;
  add_sub_seq_nbit #(.WIDTH(W), .CHUNK(CH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
`ifdef ACCUM_EN
    , .acc_sel(acc_sel)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input string tag, input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    mode = m;
    a = x;
    b = y;
    step();
    in_valid = 1'b0;
    a = 8'hAA;
    b = 8'h55;
    mode = ~m;
  endtask
  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(N));
  endtask
  task automatic result(input string tag, input logic [W-1:0] s, input logic c, input logic o, input logic z, input logic n);
    chk({tag, "_sum"}, 32'(sum), 32'(s));
    chk({tag, "_cout"}, 32'(cout), 32'(c));
    chk({tag, "_ovf"}, 32'(ovf), 32'(o));
    chk({tag, "_zero"}, 32'(zero), 32'(z));
    chk({tag, "_neg"}, 32'(neg), 32'(n));
  endtask
  task automatic ack(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ack_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ack_in_ready"}, 32'(in_ready), 32'd1);
  endtask
  task automatic op(input string tag, input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic [W-1:0] s, input logic c, input logic o, input logic z, input logic n);
    send(tag, m, x, y);
    wait_done(tag);
    result(tag, s, c, o, z, n);
    ack(tag);
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    result("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    op("add_3c_0f", 1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0, 1'b0, 1'b0);
    op("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    op("sub_07_07", 1'b1, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    op("add_a5_5a", 1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    send("hold", 1'b0, 8'h12, 8'h34);
    wait_done("hold");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = 8'h99;
      b = 8'h99;
      step();
      chk("hold_sum", 32'(sum), 32'h46);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    result("hold", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
    ack("hold");
    chk("hold_idle_out_valid", 32'(out_valid), 32'd0);
    send("abort", 1'b1, 8'h90, 8'h10);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    result("abort", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    op("after_abort", 1'b0, 8'h21, 8'h10, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ACCUM_EN
    acc_sel = 1'b0;
    op("acc_load", 1'b0, 8'h10, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    acc_sel = 1'b1;
    op("acc_add", 1'b0, 8'hFF, 8'h05, 8'h15, 1'b0, 1'b0, 1'b0, 1'b0);
    op("acc_sub", 1'b1, 8'h00, 8'h20, 8'hF5, 1'b0, 1'b0, 1'b0, 1'b1);
    acc_sel = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
